// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared 16-bit memory port: single-word
// instruction fetches and fixed-length vector bursts, round-robin on ties.
module mem_arbiter #(
  parameter int BURST_LEN = 16
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_gnt,
  output logic        f_valid,
  output logic [15:0] f_data,
  input  logic        v_req,
  input  logic        v_we,
  input  logic [15:0] v_addr,
  input  logic [15:0] v_wdata,
  output logic        v_gnt,
  output logic        v_ack,
  output logic        v_last,
  output logic [15:0] v_rdata,
  output logic [15:0] Addr,
  output logic        RD,
  output logic        WR,
  output logic [15:0] DataOut,
  input  logic [15:0] DataIn
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    FWAIT  = 3'd2,
    VRD    = 3'd3,
    VDRAIN = 3'd4,
    VWR    = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntInc;
  logic          lastOwnerVec;
  logic          rdPipe;
  logic          fetchWins;
  logic          vecWins;

  // Round-robin pick: on a tie the requester that did not win last time goes
  always_comb begin
    fetchWins = 1'b0;
    vecWins   = 1'b0;
    if (f_req && v_req) begin
      fetchWins = lastOwnerVec;
      vecWins   = !lastOwnerVec;
    end else begin
      fetchWins = f_req;
      vecWins   = v_req;
    end
  end

  assign cntInc = cnt + CW'(1);

  // Main sequencer: arbitration, memory strobes and requester handshakes
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      lastOwnerVec <= 1'b1;
      rdPipe       <= 1'b0;
      f_gnt        <= 1'b0;
      f_valid      <= 1'b0;
      f_data       <= 16'h0000;
      v_gnt        <= 1'b0;
      v_ack        <= 1'b0;
      v_last       <= 1'b0;
      v_rdata      <= 16'h0000;
      Addr         <= 16'h0000;
      RD           <= 1'b0;
      WR           <= 1'b0;
      DataOut      <= 16'h0000;
    end else begin
      f_gnt   <= 1'b0;
      v_gnt   <= 1'b0;
      f_valid <= 1'b0;
      v_ack   <= 1'b0;
      v_last  <= 1'b0;
      // DataIn lags RD by one cycle, so remember which cycles carried a burst read
      rdPipe  <= RD && (state == VRD);
      case (state)
        IDLE: begin
          if (fetchWins) begin
            lastOwnerVec <= 1'b0;
            f_gnt        <= 1'b1;
            Addr         <= f_addr;
            RD           <= 1'b1;
            state        <= FETCH;
          end else if (vecWins) begin
            lastOwnerVec <= 1'b1;
            v_gnt        <= 1'b1;
            Addr         <= v_addr;
            cnt          <= '0;
            if (v_we) begin
              DataOut <= v_wdata;
              WR      <= 1'b1;
              v_ack   <= 1'b1;
              state   <= VWR;
            end else begin
              RD    <= 1'b1;
              state <= VRD;
            end
          end else begin
            state <= IDLE;
          end
        end
        FETCH: begin
          RD    <= 1'b0;
          state <= FWAIT;
        end
        FWAIT: begin
          f_data  <= DataIn;
          f_valid <= 1'b1;
          state   <= IDLE;
        end
        VRD: begin
          Addr  <= Addr + 16'd1;
          v_ack <= rdPipe;
          if (rdPipe) begin
            v_rdata <= DataIn;
          end
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            RD    <= 1'b0;
            state <= VDRAIN;
          end else begin
            cnt <= cntInc;
          end
        end
        VDRAIN: begin
          v_rdata <= DataIn;
          v_ack   <= 1'b1;
          v_last  <= 1'b1;
          state   <= IDLE;
        end
        VWR: begin
          if (cnt != LAST_CNT) begin
            Addr    <= Addr + 16'd1;
            DataOut <= v_wdata;
            v_ack   <= 1'b1;
            v_last  <= (cntInc == LAST_CNT);
            cnt     <= cntInc;
          end else begin
            cnt   <= '0;
            WR    <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          RD    <= 1'b0;
          WR    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
